// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : mem_arb_pkg                                             |
// | Desc   : Shared encodings for the unified-memory port arbiter.   |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
package mem_arb_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'b00,
      OWN_IF   = 2'b01,
      OWN_DM   = 2'b10
   } arb_owner_t;

endpackage
`default_nettype wire

// File: rtl/arb_lat_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : arb_lat_counter                                         |
// | Desc   : Loadable up-counter with a terminal flag at MAX_CNT.    |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module arb_lat_counter
   import mem_arb_pkg::*;
#(
   parameter int MAX_CNT = 2
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clr,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_inc,
   output logic             o_term
);

   localparam logic [CNT_W-1:0] c_MAX = CNT_W'(MAX_CNT);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n || i_clr) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_inc) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_term = (r_cnt == c_MAX);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : mem_port_arbiter                                        |
// | Desc   : IF/DM arbiter for a single-ported fixed-latency memory, |
// |          DM priority with an IF starvation guard.                |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 16,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_LIM = 3
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_done,
   output logic              if_stall,
   input  logic              dm_req,
   input  logic              dm_wr,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_done,
   output logic              dm_stall,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int c_STREAK_W = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
   localparam logic [c_STREAK_W-1:0] c_STREAK_MAX = c_STREAK_W'(STARVE_LIM);

   arb_state_t              r_state, w_state_nxt;
   arb_owner_t              r_owner, w_owner_nxt;
   logic [c_STREAK_W-1:0]   r_streak, w_streak_nxt;
   logic                    r_dm_wr, w_dm_wr_nxt;
   logic                    w_cnt_clr, w_cnt_load, w_cnt_inc, w_term;
   logic                    w_dm_wins;

   arb_lat_counter #(
      .MAX_CNT (MEM_LAT)
   ) u_lat_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clr      (w_cnt_clr),
      .i_load     (w_cnt_load),
      .i_load_val (CNT_W'(1)),
      .i_inc      (w_cnt_inc),
      .o_term     (w_term)
   );

   // IF only overtakes a pending DM once DM has won STARVE_LIM times in a row.
   assign w_dm_wins = dm_req && !(if_req && (r_streak == c_STREAK_MAX));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_owner  <= OWN_NONE;
         r_streak <= '0;
         r_dm_wr  <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_owner  <= w_owner_nxt;
         r_streak <= w_streak_nxt;
         r_dm_wr  <= w_dm_wr_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_owner_nxt  = r_owner;
      w_streak_nxt = r_streak;
      w_dm_wr_nxt  = r_dm_wr;
      w_cnt_clr    = 1'b0;
      w_cnt_load   = 1'b0;
      w_cnt_inc    = 1'b0;
      mem_en       = 1'b0;
      mem_wr       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      if_done      = 1'b0;
      if_rdata     = '0;
      dm_done      = 1'b0;
      dm_rdata     = '0;

      // Outputs stay quiet while reset is held, even with requests pending.
      if (rst_n) begin
         case (r_state)
            IDLE: begin
               if (if_req || dm_req) begin
                  mem_en      = 1'b1;
                  w_state_nxt = BUSY;
                  w_cnt_load  = 1'b1;
                  if (w_dm_wins) begin
                     w_owner_nxt = OWN_DM;
                     w_dm_wr_nxt = dm_wr;
                     mem_wr      = dm_wr;
                     mem_addr    = dm_addr;
                     mem_wdata   = dm_wdata;
                     if (!if_req) begin
                        w_streak_nxt = '0;
                     end else if (r_streak != c_STREAK_MAX) begin
                        w_streak_nxt = r_streak + 1'b1;
                     end
                  end else begin
                     w_owner_nxt  = OWN_IF;
                     w_dm_wr_nxt  = 1'b0;
                     mem_addr     = if_addr;
                     w_streak_nxt = '0;
                  end
               end
            end
            BUSY: begin
               if (w_term) begin
                  w_state_nxt = IDLE;
                  w_owner_nxt = OWN_NONE;
                  w_cnt_clr   = 1'b1;
                  if (r_owner == OWN_IF) begin
                     if_done  = 1'b1;
                     if_rdata = mem_rdata;
                  end else if (r_owner == OWN_DM) begin
                     dm_done  = 1'b1;
                     dm_rdata = r_dm_wr ? '0 : mem_rdata;
                  end
               end else begin
                  w_cnt_inc = 1'b1;
               end
            end
            default: begin
               w_state_nxt = IDLE;
               w_owner_nxt = OWN_NONE;
            end
         endcase
      end
   end

   assign if_stall = if_req & ~if_done;
   assign dm_stall = dm_req & ~dm_done;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tb_mem_port_arbiter                                     |
// | Desc   : Directed vector bench for mem_port_arbiter.             |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module tb_mem_port_arbiter;

   localparam logic [15:0] c_KEY = 16'hA5E5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Main instance, MEM_LAT = 2
   logic        rst_n, if_req, dm_req, dm_wr;
   logic [15:0] if_addr, dm_addr, dm_wdata;
   logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        if_done, if_stall, dm_done, dm_stall, mem_en, mem_wr;
   logic [15:0] r_rd_pipe [0:1];

   // Second instance, MEM_LAT = 1
   logic        rst1_n, if_req1, dm_req1, dm_wr1;
   logic [15:0] if_addr1, dm_addr1, dm_wdata1;
   logic [15:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
   logic        if_done1, if_stall1, dm_done1, dm_stall1, mem_en1, mem_wr1;

   int n_cmp = 0;
   int n_err = 0;

   mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(2), .STARVE_LIM(3)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
      .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1), .STARVE_LIM(3)) u_dut1 (
      .clk(clk), .rst_n(rst1_n),
      .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_done(if_done1), .if_stall(if_stall1),
      .dm_req(dm_req1), .dm_wr(dm_wr1), .dm_addr(dm_addr1), .dm_wdata(dm_wdata1),
      .dm_rdata(dm_rdata1), .dm_done(dm_done1), .dm_stall(dm_stall1),
      .mem_en(mem_en1), .mem_wr(mem_wr1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
      .mem_rdata(mem_rdata1)
   );

   // Memory models: data = addr ^ c_KEY, junk whenever nothing was issued.
   always @(posedge clk) begin
      r_rd_pipe[1] <= r_rd_pipe[0];
      r_rd_pipe[0] <= mem_en ? (mem_addr ^ c_KEY) : 16'hDEAD;
      mem_rdata1   <= mem_en1 ? (mem_addr1 ^ c_KEY) : 16'hDEAD;
   end
   assign mem_rdata = r_rd_pipe[1];

   typedef struct {
      logic        rst_n, ireq;
      logic [15:0] iaddr;
      logic        dreq, dwr;
      logic [15:0] daddr, dwdata;
      logic        en, wr;
      logic [15:0] addr, wdata;
      logic        idone;
      logic [15:0] irdata;
      logic        ddone;
      logic [15:0] drdata;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, ir, input logic [15:0] ia,
                      input logic dr, dw, input logic [15:0] da, dd,
                      input logic en, wr, input logic [15:0] ad, wd,
                      input logic idn, input logic [15:0] ird,
                      input logic ddn, input logic [15:0] drd);
      vec_t v;
      v.rst_n = r;   v.ireq = ir;   v.iaddr = ia;
      v.dreq = dr;   v.dwr = dw;    v.daddr = da;   v.dwdata = dd;
      v.en = en;     v.wr = wr;     v.addr = ad;    v.wdata = wd;
      v.idone = idn; v.irdata = ird; v.ddone = ddn; v.drdata = drd;
      vecs.push_back(v);
   endtask

   task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @step %0d: got %h, expected %h", nm, idx, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      //  rst ir iaddr     dr dw daddr     dwdata    | en wr addr      wdata     idn irdata    ddn drdata
      add(0, 1, 16'h0100, 1, 0, 16'h0200, 16'h0000,  0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000);
      add(0, 1, 16'h0100, 1, 0, 16'h0200, 16'h0000,  0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000);
      add(1, 1, 16'h0100, 1, 0, 16'h0200, 16'h0000,  1, 0, 16'h0200, 16'h0000, 0, 16'h0000, 0, 16'h0000);
      add(1, 1, 16'h0100, 1, 0, 16'h0200, 16'h0000,  0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000);
      add(1, 1, 16'h0100, 1, 0, 16'h0200, 16'h0000,  0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 16'hA7E5);
      add(1, 1, 16'h0100, 0, 0, 16'h0000, 16'h0000,  1, 0, 16'h0100, 16'h0000, 0, 16'h0000, 0, 16'h0000);
      add(1, 1, 16'h0100, 0, 0, 16'h0000, 16'h0000,  0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000);
      add(1, 1, 16'h0100, 0, 0, 16'h0000, 16'h0000,  0, 0, 16'h0000, 16'h0000, 1, 16'hA4E5, 0, 16'h0000);
      // IF-only read of 0x0040; address wiggle while busy must not matter
      add(1, 1, 16'h0040, 0, 0, 16'h0000, 16'h0000,  1, 0, 16'h0040, 16'h0000, 0, 16'h0000, 0, 16'h0000);
      add(1, 1, 16'h7777, 0, 0, 16'h0000, 16'h0000,  0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000);
      add(1, 1, 16'h7777, 0, 0, 16'h0000, 16'h0000,  0, 0, 16'h0000, 16'h0000, 1, 16'hA5A5, 0, 16'h0000);
      // Simultaneous: DM write first, then IF
      add(1, 1, 16'h0040, 1, 1, 16'h1000, 16'h1234,  1, 1, 16'h1000, 16'h1234, 0, 16'h0000, 0, 16'h0000);
      add(1, 1, 16'h0040, 1, 1, 16'h1000, 16'h1234,  0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000);
      add(1, 1, 16'h0040, 1, 1, 16'h1000, 16'h1234,  0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 16'h0000);
      add(1, 1, 16'h0040, 0, 0, 16'h0000, 16'h0000,  1, 0, 16'h0040, 16'h0000, 0, 16'h0000, 0, 16'h0000);
      add(1, 1, 16'h0040, 0, 0, 16'h0000, 16'h0000,  0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000);
      add(1, 1, 16'h0040, 0, 0, 16'h0000, 16'h0000,  0, 0, 16'h0000, 16'h0000, 1, 16'hA5A5, 0, 16'h0000);
      // Starvation guard: DM, DM, DM, IF, then DM again
      for (int k = 0; k < 3; k++) begin
         add(1, 1, 16'h0300, 1, 0, 16'h0400, 16'h0000, 1, 0, 16'h0400, 16'h0000, 0, 16'h0000, 0, 16'h0000);
         add(1, 1, 16'h0300, 1, 0, 16'h0400, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000);
         add(1, 1, 16'h0300, 1, 0, 16'h0400, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 16'hA1E5);
      end
      add(1, 1, 16'h0300, 1, 0, 16'h0400, 16'h0000,  1, 0, 16'h0300, 16'h0000, 0, 16'h0000, 0, 16'h0000);
      add(1, 1, 16'h0300, 1, 0, 16'h0400, 16'h0000,  0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000);
      add(1, 1, 16'h0300, 1, 0, 16'h0400, 16'h0000,  0, 0, 16'h0000, 16'h0000, 1, 16'hA6E5, 0, 16'h0000);
      add(1, 1, 16'h0300, 1, 0, 16'h0400, 16'h0000,  1, 0, 16'h0400, 16'h0000, 0, 16'h0000, 0, 16'h0000);
      add(1, 1, 16'h0300, 1, 0, 16'h0400, 16'h0000,  0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000);
      add(1, 1, 16'h0300, 1, 0, 16'h0400, 16'h0000,  0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 16'hA1E5);
      // Reset mid-access, reissue, then requester drops req mid-access
      add(1, 0, 16'h0000, 1, 0, 16'h0500, 16'h0000,  1, 0, 16'h0500, 16'h0000, 0, 16'h0000, 0, 16'h0000);
      add(0, 0, 16'h0000, 1, 0, 16'h0500, 16'h0000,  0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000);
      add(1, 0, 16'h0000, 1, 0, 16'h0500, 16'h0000,  1, 0, 16'h0500, 16'h0000, 0, 16'h0000, 0, 16'h0000);
      add(1, 0, 16'h0000, 0, 0, 16'h0500, 16'h0000,  0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000);
      add(1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000,  0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 1, 16'hA0E5);
      add(1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000,  0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 16'h0000);

      rst1_n = 1'b0; if_req1 = 1'b1; if_addr1 = 16'h0010;
      dm_req1 = 1'b0; dm_wr1 = 1'b0; dm_addr1 = 16'h0000; dm_wdata1 = 16'h0000;

      for (int i = 0; i < vecs.size(); i++) begin
         rst_n    = vecs[i].rst_n;
         if_req   = vecs[i].ireq;
         if_addr  = vecs[i].iaddr;
         dm_req   = vecs[i].dreq;
         dm_wr    = vecs[i].dwr;
         dm_addr  = vecs[i].daddr;
         dm_wdata = vecs[i].dwdata;
         @(negedge clk);
         chk("mem_en", i, 16'(mem_en), 16'(vecs[i].en));
         chk("mem_wr", i, 16'(mem_wr), 16'(vecs[i].wr));
         if (vecs[i].en) chk("mem_addr", i, mem_addr, vecs[i].addr);
         if (vecs[i].en && vecs[i].wr) chk("mem_wdata", i, mem_wdata, vecs[i].wdata);
         chk("if_done", i, 16'(if_done), 16'(vecs[i].idone));
         chk("if_rdata", i, if_rdata, vecs[i].irdata);
         chk("dm_done", i, 16'(dm_done), 16'(vecs[i].ddone));
         chk("dm_rdata", i, dm_rdata, vecs[i].drdata);
         chk("if_stall", i, 16'(if_stall), 16'(vecs[i].ireq & ~vecs[i].idone));
         chk("dm_stall", i, 16'(dm_stall), 16'(vecs[i].dreq & ~vecs[i].ddone));
         @(posedge clk);
         #1;
      end

      // MEM_LAT = 1: back-to-back IF reads, issue/done alternate every cycle
      rst1_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         if (k == 2) if_addr1 = 16'h0020;
         @(negedge clk);
         chk("lat1_mem_en", 100 + k, 16'(mem_en1), 16'((k % 2) == 0));
         chk("lat1_if_done", 100 + k, 16'(if_done1), 16'((k % 2) == 1));
         chk("lat1_en_and_done", 100 + k, 16'(mem_en1 & if_done1), 16'h0000);
         chk("lat1_dm_done", 100 + k, 16'(dm_done1), 16'h0000);
         if ((k % 2) == 0)
            chk("lat1_mem_addr", 100 + k, mem_addr1, (k == 0) ? 16'h0010 : 16'h0020);
         else
            chk("lat1_if_rdata", 100 + k, if_rdata1, (k == 1) ? 16'hA5F5 : 16'hA5C5);
         @(posedge clk);
         #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between the fetch stage (IF port) and the memory stage (DM port) of the 5-stage pipeline.
- Grants one access at a time and sequences it through the memory latency.
- Returns read data with a one-cycle done pulse, and drives per-port stall lines that the pipeline ORs into the hazard stall.
- DM has priority, with a starvation guard for IF.

Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width
- MEM_LAT, 2, cycles from issue to read data/write completion; legal range 1..15
- STARVE_LIM, 3, maximum consecutive DM grants while IF is waiting

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- if_req  in  1  fetch read request; level, held until if_done
- if_addr  in  ADDR_W  fetch address; stable while if_req
- if_rdata  out  DATA_W  instruction; valid only when if_done
- if_done  out  1  one-cycle completion pulse for IF
- if_stall  out  1  if_req & ~if_done
- dm_req  in  1  data request; level, held until dm_done
- dm_wr  in  1  1 = write, 0 = read; stable while dm_req
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  write data
- dm_rdata  out  DATA_W  load data; valid only when dm_done
- dm_done  out  1  one-cycle completion pulse for DM
- dm_stall  out  1  dm_req & ~dm_done
- mem_en  out  1  one-cycle issue strobe to memory
- mem_wr  out  1  write qualifier, valid with mem_en
- mem_addr  out  ADDR_W  issue address, valid with mem_en
- mem_wdata  out  DATA_W  issue write data, valid with mem_en
- mem_rdata  in  DATA_W  memory read data; valid exactly MEM_LAT cycles after mem_en

Behaviour:
- Reset state: IDLE, owner = NONE, cnt = 0, streak = 0.
  - All outputs read 0 during and after reset until the first request: mem_en, mem_wr, done pulses and rdata; stall lines follow their equations.
- States:
  - IDLE: no access in flight.
  - BUSY: access in flight; owner and cnt are registered.
- IDLE, no req: hold; mem_en = 0.
- IDLE with request(s): same cycle (combinational), pick the winner and drive mem_en = 1 with the winner's addr/wr/wdata.
  - IF issues are always reads, so mem_wr = 0.
  - Next state BUSY, owner = winner, cnt = 1.
- Arbitration:
  - DM wins unless streak == STARVE_LIM and if_req = 1.
  - Lone requester always wins.
- Streak update at each grant:
  - DM granted while if_req = 1: streak + 1, saturating.
  - IF granted: streak = 0.
  - DM granted with if_req = 0: streak = 0.
- BUSY, cnt < MEM_LAT: cnt + 1; mem_en = 0; no new issue.
- BUSY, cnt == MEM_LAT:
  - Assert the owner's done for one cycle.
  - Owner's rdata = mem_rdata; the other port's rdata = 0.
  - Next state IDLE.
- Latency: request first seen in IDLE at cycle t gives done at t + MEM_LAT.
  - Throughput: one access per MEM_LAT + 1 cycles; the done cycle is followed by an IDLE issue cycle.
- Write completion: dm_done also pulses at t + MEM_LAT; dm_rdata = 0 for writes.
- Owner drops req mid-access: the access still completes and done still pulses. The requester ignores it. No abort.
- Address/data change while BUSY: ignored; mem signals were issued at grant.
- Simultaneous reqs in IDLE: resolved per arbitration above; the loser stays stalled.
- Reset mid-access: next cycle IDLE.
  - The in-flight response is discarded and no done pulse is produced.
  - streak and cnt are cleared.
- if_done and dm_done are never high in the same cycle.
- mem_en is never high in BUSY.

Decomposition:
- Shared package mem_arb_pkg:
  - state encoding: IDLE = 1'b0, BUSY = 1'b1
  - owner encoding: NONE = 2'b00, IF = 2'b01, DM = 2'b10
  - counter width constant CNT_W = 4
- One natural sub-module, arb_lat_counter:
  - loadable up-counter with terminal flag cnt == MEM_LAT.
  - Instantiated once.
  - Also reusable by the future cache-miss sequencer.

Test Plan:
- Reset with if_req = dm_req = 1 held low-reset for 2 cycles -> mem_en = 0, if_done = dm_done = 0, state IDLE; first grant on the cycle after rst_n rises goes to DM.
- IF-only read, if_addr = 0x0040, MEM_LAT = 2, memory returns 0xA5A5 -> mem_en pulses at t with addr 0x0040; if_done = 1 and if_rdata = 0xA5A5 at t+2; if_stall high at t and t+1.
- Both request at t, DM write addr 0x1000 data 0x1234 -> DM issues at t (mem_wr = 1), dm_done at t+2, IF issues at t+3, if_done at t+5.
- DM re-requests continuously with if_req held, STARVE_LIM = 3 -> grants DM, DM, DM, then IF; streak returns to 0 after the IF grant.
- Reset asserted at t+1 of a DM read -> no dm_done at t+2, IDLE at t+2, next issue when rst_n = 1 and a request is present.
- MEM_LAT = 1 back-to-back IF reads -> done every 2 cycles; mem_en never high in a done cycle.
